// File: rtl/osd_pkg.sv
// Shared OSD definitions: writer FSM states and the printable-ASCII range.
package osd_pkg;

    typedef enum logic [1:0] {
        RECV   = 2'd0,
        FLUSH  = 2'd1,
        LEN_LO = 2'd2,
        LEN_HI = 2'd3
    } osd_state_e;

    localparam logic [7:0] ASCII_SPACE     = 8'h20;
    localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;

endpackage

// File: rtl/char_buf_writer_if.sv
// Byte-stream input, character-RAM write port and string status of the OSD
// character buffer writer. The writer uses the slave modport; the payload
// source and RAM/renderer side use the master modport.
interface char_buf_writer_if #(
    parameter int CHAR_BUFFER_ADDR_WIDTH = 12
) ();
    import osd_pkg::*;

    logic [7:0]                        s_char_data;
    logic                              s_char_valid;
    logic                              s_char_last;
    logic                              s_char_ready;
    logic [CHAR_BUFFER_ADDR_WIDTH-1:0] ram_wr_addr;
    logic [7:0]                        ram_wr_data;
    logic                              ram_wr_en;
    logic [CHAR_BUFFER_ADDR_WIDTH-1:0] str_len;
    logic                              str_done;
    logic                              str_overflow;

    modport master (
        output s_char_data, s_char_valid, s_char_last,
        input  s_char_ready, ram_wr_addr, ram_wr_data, ram_wr_en,
        input  str_len, str_done, str_overflow
    );

    modport slave (
        input  s_char_data, s_char_valid, s_char_last,
        output s_char_ready, ram_wr_addr, ram_wr_data, ram_wr_en,
        output str_len, str_done, str_overflow
    );

endinterface

// File: rtl/char_buf_writer.sv
// OSD character buffer writer: stores an incoming payload string at RAM
// addresses 0.. and, once all characters are written, commits the 16-bit
// length at STRLENDATA_SAVED_ADDR (low) / STRLENDATA_SAVED_ADDR+1 (high) so
// the renderer never sees a length ahead of its characters.
// Optional macro CHAR_BUF_WRITER_FILTER_EN replaces non-printable bytes
// (< 0x20 or > 0x7E) with a space before they are written.
module char_buf_writer
    import osd_pkg::*;
#(
    parameter int STRLENDATA_SAVED_ADDR  = 1023,
    parameter int CHAR_BUFFER_ADDR_WIDTH = 12
) (
    input  logic             clk,
    input  logic             resetn,
    char_buf_writer_if.slave bus
);

    localparam int AW = CHAR_BUFFER_ADDR_WIDTH;
    localparam logic [AW-1:0] LEN_LO_ADDR = AW'(STRLENDATA_SAVED_ADDR);
    localparam logic [AW-1:0] LEN_HI_ADDR = AW'(STRLENDATA_SAVED_ADDR + 1);

    // Character substitution applied on the RAM data path only.
    function automatic logic [7:0] filter_char(input logic [7:0] c);
`ifdef CHAR_BUF_WRITER_FILTER_EN
        return ((c < ASCII_SPACE) || (c > ASCII_PRINT_MAX)) ? ASCII_SPACE : c;
`else
        return c;
`endif
    endfunction

    osd_state_e    state_q, state_d;
    logic [AW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [AW-1:0] str_len_q, str_len_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   len16;

    // count_q doubles as the saturated packet length while the length is
    // being committed, so no separate length register is needed.
    assign len16 = 16'(count_q);

    // Next-state and next-output computation for the writer FSM.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ready_d   = 1'b1;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        str_len_d = str_len_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;

        case (state_q)
            RECV: begin
                if (bus.s_char_valid && ready_q) begin
                    // The first byte of a packet always finds count at 0.
                    if (count_q == '0) begin
                        ovf_d = 1'b0;
                    end
                    if (count_q < LEN_LO_ADDR) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = count_q;
                        wr_data_d = filter_char(bus.s_char_data);
                        count_d   = count_q + 1'b1;
                    end else begin
                        // Buffer full: byte consumed, nothing written.
                        ovf_d = 1'b1;
                    end
                    if (bus.s_char_last) begin
                        state_d = FLUSH;
                        ready_d = 1'b0;
                    end
                end
            end
            FLUSH: begin
                ready_d   = 1'b0;
                wr_en_d   = 1'b1;
                wr_addr_d = LEN_LO_ADDR;
                wr_data_d = len16[7:0];
                state_d   = LEN_LO;
            end
            LEN_LO: begin
                ready_d   = 1'b0;
                wr_en_d   = 1'b1;
                wr_addr_d = LEN_HI_ADDR;
                wr_data_d = len16[15:8];
                state_d   = LEN_HI;
            end
            LEN_HI: begin
                done_d    = 1'b1;
                str_len_d = count_q;
                count_d   = '0;
                state_d   = RECV;
            end
            default: begin
                state_d = RECV;
            end
        endcase
    end

    // State and registered-output flops; async reset aborts any packet.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= RECV;
            count_q   <= '0;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            str_len_q <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            str_len_q <= str_len_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.s_char_ready = ready_q;
    assign bus.ram_wr_en    = wr_en_q;
    assign bus.ram_wr_addr  = wr_addr_q;
    assign bus.ram_wr_data  = wr_data_q;
    assign bus.str_len      = str_len_q;
    assign bus.str_done     = done_q;
    assign bus.str_overflow = ovf_q;

endmodule

// File: tb/tb_char_buf_writer.sv
// Scoreboard bench for char_buf_writer: stimulus pushes expected RAM writes
// and committed lengths; a negedge monitor pops and compares them.
module tb_char_buf_writer;
    import osd_pkg::*;

    localparam int AW    = 12;
    localparam int SAVED = 1023;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    char_buf_writer_if #(.CHAR_BUFFER_ADDR_WIDTH(AW)) bus ();

    char_buf_writer #(
        .STRLENDATA_SAVED_ADDR (SAVED),
        .CHAR_BUFFER_ADDR_WIDTH(AW)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    wr_t exp_q[$];
    int  len_q[$];
    wr_t mon_e;
    int  n_pass = 0;
    int  n_total = 0;
    int  done_cnt = 0;
    int  low_run = 0;
    int  last_low_run = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic push_wr(input int addr, input logic [7:0] data);
        wr_t e;
        e.addr = AW'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every RAM write and every length commit.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.ram_wr_en) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write: addr %0d data 0x%02h, expected no write",
                             bus.ram_wr_addr, bus.ram_wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", bus.ram_wr_addr, mon_e.addr);
                    check("wr_data", bus.ram_wr_data, mon_e.data);
                end
            end
            if (bus.str_done) begin
                done_cnt++;
                if (len_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: str_len %0d, expected no commit", bus.str_len);
                end else begin
                    check("str_len_at_done", bus.str_len, len_q.pop_front());
                end
            end
            if (!bus.s_char_ready) begin
                low_run++;
            end else if (low_run != 0) begin
                last_low_run = low_run;
                low_run = 0;
            end
        end else begin
            low_run = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; holds the byte until the accepting edge.
    task automatic send(input logic [7:0] b, input logic last);
        int g = 0;
        while (!bus.s_char_ready && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 50) check("ready_timeout", 0, 1);
        bus.s_char_data  = b;
        bus.s_char_valid = 1'b1;
        bus.s_char_last  = last;
        @(posedge clk);
        #1;
        bus.s_char_valid = 1'b0;
        bus.s_char_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int g = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0) && g < 40) begin
            @(posedge clk);
            #1;
            g++;
        end
        idle(2);
        check({"drain_", name}, exp_q.size() + len_q.size(), 0);
    endtask

    initial begin
        int d0;
        logic [7:0] b;
        bus.s_char_data  = 8'h00;
        bus.s_char_valid = 1'b0;
        bus.s_char_last  = 1'b0;

        // Reset state
        #12;
        check("rst_ready", bus.s_char_ready, 0);
        check("rst_wr_en", bus.ram_wr_en, 0);
        check("rst_str_len", bus.str_len, 0);
        check("rst_overflow", bus.str_overflow, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(1);
        check("ready_after_reset", bus.s_char_ready, 1);

        // "HI"
        push_wr(0, 8'h48); push_wr(1, 8'h49); push_wr(1023, 8'h02); push_wr(1024, 8'h00);
        len_q.push_back(2);
        d0 = done_cnt;
        send(8'h48, 1'b0);
        send(8'h49, 1'b1);
        drain("hi");
        check("hi_done_pulses", done_cnt - d0, 1);
        check("hi_str_len", bus.str_len, 2);
        check("hi_ready_low_cycles", last_low_run, 3);

        // Single byte packet
        push_wr(0, 8'h41); push_wr(1023, 8'h01); push_wr(1024, 8'h00);
        len_q.push_back(1);
        send(8'h41, 1'b1);
        drain("single");
        check("single_str_len", bus.str_len, 1);

        // last without valid is ignored
        d0 = done_cnt;
        bus.s_char_last = 1'b1;
        idle(3);
        bus.s_char_last = 1'b0;
        check("last_no_valid_done", done_cnt - d0, 0);
        check("last_no_valid_ready", bus.s_char_ready, 1);

        // Valid toggling "ABC"
        push_wr(0, 8'h41); push_wr(1, 8'h42); push_wr(2, 8'h43);
        push_wr(1023, 8'h03); push_wr(1024, 8'h00);
        len_q.push_back(3);
        send(8'h41, 1'b0); idle(1);
        send(8'h42, 1'b0); idle(1);
        send(8'h43, 1'b1);
        drain("toggle");
        check("toggle_str_len", bus.str_len, 3);

        // 1030-byte overflow packet
        for (int i = 0; i < 1023; i++) push_wr(i, 8'(8'h41 + (i % 26)));
        push_wr(1023, 8'hFF); push_wr(1024, 8'h03);
        len_q.push_back(1023);
        for (int i = 0; i < 1030; i++) begin
            b = 8'(8'h41 + (i % 26));
            send(b, (i == 1029));
            if (i == 1021) check("ovf_not_yet", bus.str_overflow, 0);
        end
        drain("overflow");
        check("ovf_str_len", bus.str_len, 1023);
        check("ovf_flag_set", bus.str_overflow, 1);

        // Following 3-byte packet clears overflow on its first byte
        push_wr(0, 8'h78); push_wr(1, 8'h79); push_wr(2, 8'h7A);
        push_wr(1023, 8'h03); push_wr(1024, 8'h00);
        len_q.push_back(3);
        send(8'h78, 1'b0);
        check("ovf_cleared_first_byte", bus.str_overflow, 0);
        send(8'h79, 1'b0);
        send(8'h7A, 1'b1);
        drain("after_ovf");
        check("after_ovf_str_len", bus.str_len, 3);

        // Reset mid-packet after 5 bytes
        push_wr(0, 8'h31); push_wr(1, 8'h32); push_wr(2, 8'h33); push_wr(3, 8'h34); push_wr(4, 8'h35);
        for (int i = 0; i < 5; i++) send(8'(8'h31 + i), 1'b0);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_chars_seen", exp_q.size(), 0);
        check("midrst_wr_en", bus.ram_wr_en, 0);
        check("midrst_wr_addr", bus.ram_wr_addr, 0);
        check("midrst_wr_data", bus.ram_wr_data, 0);
        check("midrst_str_len", bus.str_len, 0);
        check("midrst_ready", bus.s_char_ready, 0);
        check("midrst_overflow", bus.str_overflow, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(1);
        push_wr(0, 8'h5A); push_wr(1023, 8'h01); push_wr(1024, 8'h00);
        len_q.push_back(1);
        send(8'h5A, 1'b1);
        drain("after_reset");
        check("after_reset_str_len", bus.str_len, 1);

        // Non-printable bytes
`ifdef CHAR_BUF_WRITER_FILTER_EN
        push_wr(0, 8'h20); push_wr(1, 8'h41); push_wr(2, 8'h20);
`else
        push_wr(0, 8'h0A); push_wr(1, 8'h41); push_wr(2, 8'h80);
`endif
        push_wr(1023, 8'h03); push_wr(1024, 8'h00);
        len_q.push_back(3);
        send(8'h0A, 1'b0);
        send(8'h41, 1'b0);
        send(8'h80, 1'b1);
        drain("filter");
        check("filter_str_len", bus.str_len, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/char_buf_writer.md
Name: char_buf_writer

Overview:
- Writer end of the OSD character buffer: takes the UDP OSD payload as a byte stream and writes it into the dual-port character RAM that the OSD character renderer reads.
- Characters go to consecutive addresses starting at 0.
- On end of packet, the string length is committed at STRLENDATA_SAVED_ADDR, so the renderer picks up the new length only after all characters are written.
- Sits between the UDP payload extractor and the character RAM write port.

Parameters:
- STRLENDATA_SAVED_ADDR, 1023: RAM address of the length low byte. The high byte goes to STRLENDATA_SAVED_ADDR+1. Also the maximum character count.
- CHAR_BUFFER_ADDR_WIDTH, 12: RAM address width. Requires STRLENDATA_SAVED_ADDR+1 < 2^CHAR_BUFFER_ADDR_WIDTH.

Ports:
- clk  in  1  single clock.
- resetn  in  1  reset, asynchronous, active-low.
- s_char_data  in  8  payload byte (ASCII).
- s_char_valid  in  1  byte valid.
- s_char_last  in  1  last byte of the packet, qualified by valid.
- s_char_ready  out  1  writer can accept a byte.
- ram_wr_addr  out  CHAR_BUFFER_ADDR_WIDTH  RAM write address.
- ram_wr_data  out  8  RAM write data.
- ram_wr_en  out  1  RAM write strobe, one write per cycle.
- str_len  out  CHAR_BUFFER_ADDR_WIDTH  last committed length.
- str_done  out  1  one-cycle pulse when a length has been committed.
- str_overflow  out  1  the current or last packet exceeded STRLENDATA_SAVED_ADDR bytes.

Behaviour:
- Reset values:
  - All outputs 0, except s_char_ready = 1 once reset is released.
  - Internal count 0, state RECV.
  - Reset applied mid-packet aborts the packet. The RAM length is left untouched, so the renderer keeps the old length (partial character overwrite is acceptable).
- Handshake:
  - A byte is accepted when s_char_valid && s_char_ready.
  - All outputs are registered.
  - An accepted byte at cycle t gives ram_wr_en = 1 at t+1 with ram_wr_addr = count and ram_wr_data = the byte.
- States and transitions:
  - RECV: s_char_ready = 1.
    - Non-last byte accepted: stay in RECV; count increments if count < STRLENDATA_SAVED_ADDR.
    - Byte accepted with s_char_last: go to FLUSH.
  - FLUSH (t+1): s_char_ready = 0; the write port carries the last character.
  - LEN_LO (t+2): write len[7:0] to STRLENDATA_SAVED_ADDR.
  - LEN_HI (t+3): write the zero-extended len[15:8] to STRLENDATA_SAVED_ADDR+1.
  - Back to RECV at t+4, where str_done = 1 for exactly one cycle, str_len is updated, and count clears to 0.
  - s_char_ready is low only in FLUSH, LEN_LO and LEN_HI.
- Length:
  - len = number of bytes accepted in the packet, saturated at STRLENDATA_SAVED_ADDR.
  - A single byte with s_char_last gives len = 1. Zero-length packets cannot occur.
- Overflow:
  - Bytes accepted while count == STRLENDATA_SAVED_ADDR are consumed with no RAM write.
  - str_overflow is set and stays set until the first byte of the next packet is accepted, which clears it (unless that packet overflows too).
- s_char_last without s_char_valid is ignored.
- Back-to-back packets: the next packet's first byte can be accepted at t+4.

Optional Feature:
- CHAR_BUF_WRITER_FILTER_EN defined: any byte < 0x20 or > 0x7E is written as 0x20 (space). Length counting is unchanged.
- Undefined: bytes are written unmodified.

Decomposition:
- Shared package osd_pkg holds:
  - FSM state enum {RECV, FLUSH, LEN_LO, LEN_HI};
  - ASCII constants ASCII_SPACE = 8'h20, ASCII_PRINT_MAX = 8'h7E.
- No sub-module. The filter is a single combinational expression inside the block.

Test Plan:
- Reset then send "HI" (0x48, 0x49 with last):
  - writes (0,0x48) at t0+1 and (1,0x49) at t0+2;
  - then (1023,0x02) and (1024,0x00);
  - str_done pulses once, str_len = 2, s_char_ready low for exactly 3 cycles.
- Single byte 0x41 with last: writes (0,0x41), (1023,0x01), (1024,0x00); str_len = 1.
- 1030-byte packet: exactly 1023 character writes at addresses 0..1022, no write for bytes 1024..1030; length bytes 0xFF/0x03; str_len = 1023; str_overflow = 1. A following 3-byte packet clears str_overflow on its first byte.
- s_char_valid toggling every other cycle with "ABC": write addresses are contiguous 0,1,2; len = 3; no writes on idle cycles.
- resetn asserted mid-packet after 5 bytes: no length write, all outputs return to 0 asynchronously. The next packet "Z" writes (0,0x5A) and len = 1.
- With CHAR_BUF_WRITER_FILTER_EN, bytes 0x0A, 0x41, 0x80: written data is 0x20, 0x41, 0x20; len = 3. Without the macro the data is 0x0A, 0x41, 0x80.
